// File: rtl/lshift_sfr_seq.sv
// lshift_sfr_seq: sequenced left-shift register with serial fill, start/done handshake, carry-out and zero flags
module lshift_sfr_seq #(
  parameter int SIZE = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] D,
  input  logic [CNTW-1:0] amt,
  input  logic            en,
  input  logic            sin,
  output logic [SIZE-1:0] Q,
  output logic            cout,
  output logic            busy,
  output logic            done,
  output logic            zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          state_q;
  logic [SIZE-1:0] q_q;
  logic [CNTW-1:0] cnt_q;
  logic            cout_q;
  // load on accepted start, shift one bit per enabled cycle, pulse done once the count runs out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          q_q     <= D;
          cnt_q   <= amt;
          cout_q  <= 1'b0;
          state_q <= (amt != '0) ? SHIFT : DONE;
        end
        SHIFT: if (en) begin
          q_q     <= {q_q[SIZE-2:0], sin};
          cout_q  <= q_q[SIZE-1];
          cnt_q   <= cnt_q - CNTW'(1);
          state_q <= (cnt_q == CNTW'(1)) ? DONE : SHIFT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Q    = q_q;
  assign cout = cout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign zero = (q_q == '0);
endmodule

// File: tb/tb_lshift_sfr_seq.sv
// tb_lshift_sfr_seq: vector table, hand-written corner sequences and randomized transactions against a stream model
module tb_lshift_sfr_seq;
  logic        clk = 1'b0;
  logic        rst, start, en, sin;
  logic [31:0] D, Q;
  logic [5:0]  amt;
  logic        cout, busy, done, zero;
  int total = 0;
  int bad = 0;
  lshift_sfr_seq #(.SIZE(32), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .D(D), .amt(amt), .en(en), .sin(sin),
    .Q(Q), .cout(cout), .busy(busy), .done(done), .zero(zero)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] d;
    logic [5:0]  a;
    logic        s;
    logic [31:0] eq;
    logic        ec;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    int nb;
    int cyc;
    nb = 0;
    cyc = 0;
    D = v.d; amt = v.a; sin = v.s; en = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      tick;
      cyc++;
    end
    chk("vec_done", done, 1);
    chk("vec_busy_cycles", nb, v.a);
    chk("vec_q", Q, v.eq);
    chk("vec_cout", cout, v.ec);
    chk("vec_zero", zero, v.eq == 0);
    tick;
    chk("vec_done_pulse", done, 0);
    chk("vec_q_hold", Q, v.eq);
  endtask
  task automatic run_rand;
    logic [127:0] w;
    logic [5:0]   a;
    logic [31:0]  qd;
    int n;
    int cyc;
    a = 6'($urandom_range(0, 63));
    qd = $urandom;
    w = {96'b0, qd};
    n = 0;
    cyc = 0;
    D = qd; amt = a; start = 1'b1; en = 1'($urandom); sin = 1'($urandom);
    tick;
    start = 1'b0;
    if (a != 0) chk("rnd_busy_after_start", busy, 1);
    while (n < a && cyc < 1000) begin
      en = 1'($urandom);
      sin = 1'($urandom);
      start = ($urandom % 4 == 0);
      D = $urandom;
      amt = 6'($urandom);
      tick;
      cyc++;
      if (en) begin
        w = (w << 1) | {127'b0, sin};
        n++;
      end
      if (n < a) begin
        chk("rnd_busy", busy, 1);
        chk("rnd_early_done", done, 0);
      end
    end
    if (cyc >= 1000) chk("rnd_timeout", 0, 1);
    chk("rnd_done", done, 1);
    chk("rnd_q", Q, w[31:0]);
    chk("rnd_cout", cout, (a != 0) ? w[32] : 1'b0);
    start = 1'b1; D = $urandom; amt = 6'($urandom);
    tick;
    start = 1'b0;
    chk("rnd_done_drop", done, 0);
    chk("rnd_idle", busy, 0);
    chk("rnd_q_hold", Q, w[31:0]);
  endtask
  initial begin
    tv[0] = '{32'h8000_0001, 6'd4,  1'b0, 32'h0000_0010, 1'b0};
    tv[1] = '{32'hC000_0000, 6'd2,  1'b1, 32'h0000_0003, 1'b1};
    tv[2] = '{32'h1234_5678, 6'd0,  1'b0, 32'h1234_5678, 1'b0};
    tv[3] = '{32'hFFFF_FFFF, 6'd40, 1'b0, 32'h0000_0000, 1'b0};
    tv[4] = '{32'h0000_0001, 6'd31, 1'b0, 32'h8000_0000, 1'b0};
    tv[5] = '{32'h0000_0001, 6'd32, 1'b0, 32'h0000_0000, 1'b1};
    tv[6] = '{32'hA5A5_A5A5, 6'd63, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tv[7] = '{32'h8000_0000, 6'd1,  1'b0, 32'h0000_0000, 1'b1};
    rst = 1'b1; start = 1'b0; en = 1'b0; sin = 1'b0; D = '0; amt = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_q", Q, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 1);
    for (int i = 0; i < 8; i++) run_vec(tv[i]);
    D = 32'h0000_0001; amt = 6'd3; sin = 1'b0; en = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      start = (i == 1);
      D = 32'hFFFF_FFFF;
      tick;
      if (i < 4) begin
        chk("stall_busy", busy, 1);
        chk("stall_done", done, 0);
      end
    end
    chk("stall_done_final", done, 1);
    chk("stall_q", Q, 32'h0000_0008);
    chk("stall_cout", cout, 0);
    en = 1'b1;
    tick;
    D = 32'hFFFF_FFFF; amt = 6'd40; sin = 1'b0; en = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("pre_rst_q", Q, 32'hFFFF_FE00);
    chk("pre_rst_cout", cout, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_q", Q, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("midrst_no_done", done, 0);
    end
    for (int i = 0; i < 40; i++) run_rand;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
